// File: rtl/h264_chroma_dc_hadamard.sv
// h264_chroma_dc_hadamard: ping-pong buffered 2x2 Hadamard on chroma DC coefficients
module h264_chroma_dc_hadamard #(
  parameter int IW = 16,
  parameter int OW = IW + 2
) (
  input  logic                 CLK2,
  input  logic                 RESET,
  input  logic                 DCSTROBEI,
  input  logic signed [IW-1:0] DCDATAI,
  output logic                 READYI,
  input  logic                 READYO,
  output logic                 DCSTROBEO,
  output logic signed [OW-1:0] DCDATAO,
  output logic [1:0]           DCIDXO,
  output logic                 CMPO,
  output logic                 ERRO
);
  typedef enum logic {S_IDLE, S_DRAIN} state_t;
  state_t r_state, w_state_n;
  logic signed [IW-1:0] r_bank [2][4];
  logic signed [OW-1:0] w_c [4];
  logic signed [OW-1:0] w_f [4];
  logic [1:0] r_full, r_tag, w_full_n, r_wcount, r_ridx, r_dcidxo;
  logic r_wsel, r_rsel, r_cmp, r_readyi, r_dcstrobeo, r_cmpo, r_erro;
  logic signed [OW-1:0] r_dcdatao;
  logic w_wr, w_fill_done, w_emit, w_free;
  assign w_wr        = DCSTROBEI & r_readyi;
  assign w_fill_done = w_wr & (r_wcount == 2'd3);
  assign w_emit      = (r_state == S_DRAIN) & READYO;
  assign w_free      = w_emit & (r_ridx == 2'd3);
  assign READYI      = r_readyi;
  assign DCSTROBEO   = r_dcstrobeo;
  assign DCDATAO     = r_dcdatao;
  assign DCIDXO      = r_dcidxo;
  assign CMPO        = r_cmpo;
  assign ERRO        = r_erro;
  // Sign-extended 2x2 Hadamard of the bank currently being drained
  always_comb begin
    for (int i = 0; i < 4; i++) w_c[i] = OW'(r_bank[r_rsel][i]);
    w_f[0] = w_c[0] + w_c[1] + w_c[2] + w_c[3];
    w_f[1] = w_c[0] - w_c[1] + w_c[2] - w_c[3];
    w_f[2] = w_c[0] + w_c[1] - w_c[2] - w_c[3];
    w_f[3] = w_c[0] - w_c[1] - w_c[2] + w_c[3];
  end
  // Bank occupancy after this edge: fill-complete sets, last output frees
  always_comb begin
    w_full_n = r_full;
    if (w_fill_done) w_full_n[r_wsel] = 1'b1;
    if (w_free) w_full_n[r_rsel] = 1'b0;
  end
  // Drain FSM next state: chain straight into the other bank if it is already full
  always_comb begin
    w_state_n = r_state;
    if (r_state == S_IDLE) w_state_n = r_full[r_rsel] ? S_DRAIN : S_IDLE;
    else if (w_free) w_state_n = r_full[~r_rsel] ? S_DRAIN : S_IDLE;
  end
  // Drain FSM state register
  always_ff @(posedge CLK2) begin
    if (RESET) r_state <= S_IDLE;
    else r_state <= w_state_n;
  end
  // Coefficient storage; contents are don't-care until the bank is marked full
  always_ff @(posedge CLK2) begin
    if (w_wr) r_bank[r_wsel][r_wcount] <= DCDATAI;
  end
  // Fill/drain pointers, component tags, ready, error and registered outputs
  always_ff @(posedge CLK2) begin
    if (RESET) begin
      r_full      <= '0;
      r_tag       <= '0;
      r_wsel      <= 1'b0;
      r_rsel      <= 1'b0;
      r_wcount    <= '0;
      r_ridx      <= '0;
      r_cmp       <= 1'b0;
      r_readyi    <= 1'b1;
      r_dcstrobeo <= 1'b0;
      r_dcdatao   <= '0;
      r_dcidxo    <= '0;
      r_cmpo      <= 1'b0;
      r_erro      <= 1'b0;
    end else begin
      if (w_wr) r_wcount <= r_wcount + 2'd1;
      if (w_fill_done) begin
        r_tag[r_wsel] <= r_cmp;
        r_cmp         <= ~r_cmp;
        r_wsel        <= ~r_wsel;
      end
      r_full      <= w_full_n;
      r_readyi    <= ~&w_full_n;
      r_dcstrobeo <= w_emit;
      if (w_emit) begin
        r_dcdatao <= w_f[r_ridx];
        r_dcidxo  <= r_ridx;
        r_cmpo    <= r_tag[r_rsel];
        r_ridx    <= r_ridx + 2'd1;
      end
      if (w_free) r_rsel <= ~r_rsel;
      if (DCSTROBEI & ~r_readyi) r_erro <= 1'b1;
    end
  end
endmodule

// File: tb/tb_h264_chroma_dc_hadamard.sv
// tb_h264_chroma_dc_hadamard: randomized and directed check against a group-level reference model
module tb_h264_chroma_dc_hadamard;
  localparam int IW = 16;
  localparam int OW = IW + 2;
  logic CLK2 = 1'b0, RESET, DCSTROBEI, READYO;
  logic signed [IW-1:0] DCDATAI;
  logic READYI, DCSTROBEO, CMPO, ERRO;
  logic signed [OW-1:0] DCDATAO;
  logic [1:0] DCIDXO;
  h264_chroma_dc_hadamard #(.IW(IW)) dut (
    .CLK2(CLK2), .RESET(RESET), .DCSTROBEI(DCSTROBEI), .DCDATAI(DCDATAI),
    .READYI(READYI), .READYO(READYO), .DCSTROBEO(DCSTROBEO), .DCDATAO(DCDATAO),
    .DCIDXO(DCIDXO), .CMPO(CMPO), .ERRO(ERRO)
  );
  always #5 CLK2 = ~CLK2;
  int n_chk = 0, n_err = 0, cyc = 0;
  bit chk_en = 0;
  int part[$], q_val[$], q_rdy[$];
  bit q_tag[$];
  bit m_tag, m_ready, m_stb, m_cmp, m_err;
  int occ, m_data, m_idx, k;
  int dlog[$], dcyc[$];
  bit clog[$];
  int e3;
  task automatic chk(string n, longint a, longint e);
    n_chk++;
    if (a != e) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", n, cyc, a, e);
    end
  endtask
  // Reference model: groups of four accepted inputs become transformed results,
  // available two edges after completion and drained in order while READYO is high.
  always @(posedge CLK2) begin
    cyc++;
    if (RESET) begin
      part.delete(); q_val.delete(); q_rdy.delete(); q_tag.delete();
      m_tag = 0; occ = 0; m_ready = 1; m_stb = 0; m_data = 0; m_idx = 0;
      m_cmp = 0; m_err = 0; k = 0;
    end else begin
      m_stb = 0;
      if (READYO && q_rdy.size() > 0 && q_rdy[0] <= cyc) begin
        m_stb = 1; m_data = q_val[k]; m_idx = k; m_cmp = q_tag[0]; k++;
        if (k == 4) begin
          k = 0;
          repeat (4) void'(q_val.pop_front());
          void'(q_tag.pop_front()); void'(q_rdy.pop_front());
          occ--;
        end
      end
      if (DCSTROBEI && !m_ready) m_err = 1;
      if (DCSTROBEI && m_ready) begin
        part.push_back(int'(DCDATAI));
        if (part.size() == 4) begin
          q_val.push_back(part[0] + part[1] + part[2] + part[3]);
          q_val.push_back(part[0] - part[1] + part[2] - part[3]);
          q_val.push_back(part[0] + part[1] - part[2] - part[3]);
          q_val.push_back(part[0] - part[1] - part[2] + part[3]);
          q_tag.push_back(m_tag); m_tag = ~m_tag;
          q_rdy.push_back(cyc + 2); occ++;
          part.delete();
        end
      end
      m_ready = occ < 2;
    end
  end
  // Every-cycle comparison against the model, plus an output log for literal checks
  always @(negedge CLK2) begin
    if (chk_en) begin
      chk("strobe", DCSTROBEO, m_stb);
      chk("readyi", READYI, m_ready);
      chk("erro", ERRO, m_err);
      chk("data", int'(DCDATAO), m_data);
      chk("idx", DCIDXO, m_idx);
      chk("cmp", CMPO, m_cmp);
      if (DCSTROBEO) begin
        dlog.push_back(int'(DCDATAO)); dcyc.push_back(cyc); clog.push_back(CMPO);
      end
    end
  end
  task automatic send(int v);
    DCSTROBEI = 1; DCDATAI = IW'(v);
    @(negedge CLK2);
    DCSTROBEI = 0;
  endtask
  task automatic idle(int n);
    DCSTROBEI = 0;
    repeat (n) @(negedge CLK2);
  endtask
  task automatic do_reset();
    RESET = 1; DCSTROBEI = 0;
    @(negedge CLK2);
    RESET = 0;
    dlog.delete(); dcyc.delete(); clog.delete();
  endtask
  initial begin
    RESET = 1; DCSTROBEI = 0; DCDATAI = '0; READYO = 1;
    @(negedge CLK2);
    chk_en = 1;
    chk("rst_readyi", READYI, 1);
    chk("rst_strobe", DCSTROBEO, 0);
    RESET = 0;
    // basic transform and latency
    send(10); send(20); send(30); send(40); e3 = cyc;
    idle(8);
    chk("basic_n", dlog.size(), 4);
    if (dlog.size() == 4) begin
      chk("basic_f0", dlog[0], 100); chk("basic_f1", dlog[1], -20);
      chk("basic_f2", dlog[2], -40); chk("basic_f3", dlog[3], 0);
      chk("basic_lat", dcyc[0], e3 + 2); chk("basic_end", dcyc[3], e3 + 5);
      chk("basic_cmp", clog[0], 0);
    end
    // component alternation, back to back
    do_reset();
    send(5); send(6); send(7); send(8); send(1); send(1); send(1); send(1);
    idle(10);
    chk("alt_n", dlog.size(), 8);
    if (dlog.size() == 8) begin
      chk("alt_g0f0", dlog[0], 26); chk("alt_g0f1", dlog[1], -2);
      chk("alt_g1f0", dlog[4], 4); chk("alt_g1f1", dlog[5], 0);
      chk("alt_g1f3", dlog[7], 0);
      chk("alt_cmp0", clog[3], 0); chk("alt_cmp1", clog[4], 1);
      chk("alt_nobubble", dcyc[4], dcyc[3] + 1);
    end
    // extremes
    do_reset();
    repeat (4) send(-32768);
    repeat (4) send(32767);
    idle(10);
    chk("ext_n", dlog.size(), 8);
    if (dlog.size() == 8) begin
      chk("ext_min", dlog[0], -131072); chk("ext_min_f1", dlog[1], 0);
      chk("ext_max", dlog[4], 131068); chk("ext_max_f3", dlog[7], 0);
    end
    // backpressure, third group dropped
    do_reset();
    READYO = 0;
    send(1); send(2); send(3); send(4);
    send(-1); send(-2); send(-3); send(-4);
    chk("bp_readyi_low", READYI, 0);
    chk("bp_err_before", ERRO, 0);
    send(99);
    chk("bp_err_set", ERRO, 1);
    send(98); send(97); send(96);
    idle(3);
    READYO = 1;
    idle(12);
    chk("bp_n", dlog.size(), 8);
    if (dlog.size() == 8) begin
      chk("bp_g0f0", dlog[0], 10); chk("bp_g0f1", dlog[1], -2);
      chk("bp_g1f0", dlog[4], -10); chk("bp_g1f2", dlog[6], 4);
    end
    chk("bp_readyi_back", READYI, 1);
    // READYO gaps during a drain
    do_reset();
    send(7); send(-3); send(11); send(2);
    for (int i = 0; i < 12; i++) begin
      READYO = i[0];
      idle(1);
    end
    READYO = 1;
    idle(4);
    chk("gap_n", dlog.size(), 4);
    // reset mid-group
    do_reset();
    send(50); send(60);
    do_reset();
    chk("rmg_readyi", READYI, 1); chk("rmg_err", ERRO, 0);
    idle(6);
    chk("rmg_none", dlog.size(), 0);
    // reset while draining f1, then a fresh group
    send(3); send(1); send(4); send(1);
    idle(2);
    RESET = 1;
    @(negedge CLK2);
    RESET = 0;
    chk("rmd_strobe", DCSTROBEO, 0);
    chk("rmd_readyi", READYI, 1);
    chk("rmd_n", dlog.size(), 1);
    idle(6);
    chk("rmd_none", dlog.size(), 1);
    dlog.delete(); clog.delete(); dcyc.delete();
    send(3); send(1); send(4); send(1);
    idle(8);
    chk("fresh_n", dlog.size(), 4);
    if (dlog.size() == 4) begin
      chk("fresh_f0", dlog[0], 9); chk("fresh_f1", dlog[1], 5);
      chk("fresh_f2", dlog[2], -1); chk("fresh_f3", dlog[3], -1);
      chk("fresh_cmp", clog[0], 0);
    end
    // randomized traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      READYO = ($urandom_range(0, 9) < 6);
      RESET = ($urandom_range(0, 499) == 0);
      DCSTROBEI = m_ready ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 19) == 0);
      DCDATAI = IW'($urandom);
      @(negedge CLK2);
    end
    RESET = 0; DCSTROBEI = 0; READYO = 1;
    idle(12);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
